// File: rtl/riscv_pkg.sv
// Shared pipeline constants, ALU op encoding and the ID/EX control bundle.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALU_OP_W   = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        AluAdd = 3'd0,
        AluSub = 3'd1,
        AluAnd = 3'd2,
        AluOr  = 3'd3,
        AluXor = 3'd4,
        AluSlt = 3'd5,
        AluSll = 3'd6,
        AluSrl = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic                ex_alu_src;
        logic [ALU_OP_W-1:0] ex_alu_op;
        logic                mem_mem_write;
        logic                mem_mem_read;
        logic                mem_branch_inst;
        logic                wb_write_mem_to_reg;
        logic                wb_write_enable;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the load held in EX and the instruction in decode.
module load_use_detect #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    output logic                  hazard_o
);

    // Both sources compared whatever the format; x0 never matches since rd must be non-zero.
    assign hazard_o = ex_valid_i & ex_mem_read_i & (ex_rd_i != '0) & id_valid_i &
                      ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, hold and flush.
// Define ID_EX_PERF_CNT_EN to add out_bubble_cnt (hazard bubble counter).
module id_ex_reg #(
    parameter int unsigned XLEN       = riscv_pkg::XLEN,
    parameter int unsigned REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic                          in_stall,
    input  logic                          in_flush,
    input  logic                          in_EX_alu_src,
    input  logic [riscv_pkg::ALU_OP_W-1:0] in_EX_alu_op,
    input  logic                          in_MEM_mem_write,
    input  logic                          in_MEM_mem_read,
    input  logic                          in_MEM_branch_inst,
    input  logic                          in_WB_write_mem_to_reg,
    input  logic                          in_WB_write_enable,
    input  logic [XLEN-1:0]               in_pc,
    input  logic [XLEN-1:0]               in_rs1_data,
    input  logic [XLEN-1:0]               in_rs2_data,
    input  logic [XLEN-1:0]               in_imm,
    input  logic [REG_ADDR_W-1:0]         in_rs1,
    input  logic [REG_ADDR_W-1:0]         in_rs2,
    input  logic [REG_ADDR_W-1:0]         in_rd,
    output logic                          out_valid,
    output logic                          out_EX_alu_src,
    output logic [riscv_pkg::ALU_OP_W-1:0] out_EX_alu_op,
    output logic                          out_MEM_mem_write,
    output logic                          out_MEM_mem_read,
    output logic                          out_MEM_branch_inst,
    output logic                          out_WB_write_mem_to_reg,
    output logic                          out_WB_write_enable,
    output logic [XLEN-1:0]               out_pc,
    output logic [XLEN-1:0]               out_rs1_data,
    output logic [XLEN-1:0]               out_rs2_data,
    output logic [XLEN-1:0]               out_imm,
    output logic [REG_ADDR_W-1:0]         out_rs1,
    output logic [REG_ADDR_W-1:0]         out_rs2,
    output logic [REG_ADDR_W-1:0]         out_rd,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]                   out_bubble_cnt,
`endif
    output logic                          out_id_stall
);

    import riscv_pkg::ctrl_t;
    import riscv_pkg::CTRL_NOP;

    logic                  valid_q, valid_d;
    ctrl_t                 ctrl_q, ctrl_d, ctrl_in;
    logic [XLEN-1:0]       pc_q, pc_d, rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]       rs2_data_q, rs2_data_d, imm_q, imm_d;
    logic [REG_ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic                  hazard;

    assign ctrl_in = '{
        ex_alu_src:          in_EX_alu_src,
        ex_alu_op:           in_EX_alu_op,
        mem_mem_write:       in_MEM_mem_write,
        mem_mem_read:        in_MEM_mem_read,
        mem_branch_inst:     in_MEM_branch_inst,
        wb_write_mem_to_reg: in_WB_write_mem_to_reg,
        wb_write_enable:     in_WB_write_enable
    };

    load_use_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_load_use_detect (
        .ex_valid_i   (valid_q),
        .ex_mem_read_i(ctrl_q.mem_mem_read),
        .ex_rd_i      (rd_q),
        .id_valid_i   (in_valid),
        .id_rs1_i     (in_rs1),
        .id_rs2_i     (in_rs2),
        .hazard_o     (hazard)
    );

    assign out_id_stall = hazard & ~in_flush & ~in_stall;

    always_comb begin
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        // Flush beats stall; hazard and empty decode only bubble when not held.
        if (in_flush || (!in_stall && (hazard || !in_valid))) begin
            valid_d    = 1'b0;
            ctrl_d     = CTRL_NOP;
            pc_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
        end else if (!in_stall) begin
            valid_d    = 1'b1;
            ctrl_d     = ctrl_in;
            pc_d       = in_pc;
            rs1_data_d = in_rs1_data;
            rs2_data_d = in_rs2_data;
            imm_d      = in_imm;
            rs1_d      = in_rs1;
            rs2_d      = in_rs2;
            rd_d       = in_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            ctrl_q     <= CTRL_NOP;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Only hazard bubbles count, which is exactly when decode is told to stall.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (out_id_stall) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign out_bubble_cnt = bubble_cnt_q;
`endif

    assign out_valid               = valid_q;
    assign out_EX_alu_src          = ctrl_q.ex_alu_src;
    assign out_EX_alu_op           = ctrl_q.ex_alu_op;
    assign out_MEM_mem_write       = ctrl_q.mem_mem_write;
    assign out_MEM_mem_read        = ctrl_q.mem_mem_read;
    assign out_MEM_branch_inst     = ctrl_q.mem_branch_inst;
    assign out_WB_write_mem_to_reg = ctrl_q.wb_write_mem_to_reg;
    assign out_WB_write_enable     = ctrl_q.wb_write_enable;
    assign out_pc                  = pc_q;
    assign out_rs1_data            = rs1_data_q;
    assign out_rs2_data            = rs2_data_q;
    assign out_imm                 = imm_q;
    assign out_rs1                 = rs1_q;
    assign out_rs2                 = rs2_q;
    assign out_rd                  = rd_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Table-driven bench for id_ex_reg: per-vector expected EX contents go through a queue.
module tb_id_ex_reg;

    localparam int KCap  = 0;
    localparam int KBub  = 1;
    localparam int KHold = 2;

    // {alu_src, alu_op[2:0], mem_write, mem_read, branch, mem_to_reg, write_enable}
    localparam logic [8:0] C_ADD  = 9'b0_000_00001;
    localparam logic [8:0] C_SUB  = 9'b0_001_00001;
    localparam logic [8:0] C_LW   = 9'b1_000_01011;
    localparam logic [8:0] C_ADDI = 9'b1_000_00001;
    localparam logic [8:0] C_SW   = 9'b1_000_10000;
    localparam logic [8:0] C_BEQ  = 9'b0_001_00100;

    typedef struct {
        logic        rst;
        logic        vld;
        logic        stl;
        logic        fls;
        logic [8:0]  ctrl;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        int          kind;
        logic        exp_stall;
        logic        hz;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_stall, in_flush;
    logic        in_EX_alu_src;
    logic [2:0]  in_EX_alu_op;
    logic        in_MEM_mem_write, in_MEM_mem_read, in_MEM_branch_inst;
    logic        in_WB_write_mem_to_reg, in_WB_write_enable;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        out_valid, out_EX_alu_src;
    logic [2:0]  out_EX_alu_op;
    logic        out_MEM_mem_write, out_MEM_mem_read, out_MEM_branch_inst;
    logic        out_WB_write_mem_to_reg, out_WB_write_enable;
    logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_id_stall;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] out_bubble_cnt;
`endif

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk                    (clk),
        .reset                  (reset),
        .in_valid               (in_valid),
        .in_stall               (in_stall),
        .in_flush               (in_flush),
        .in_EX_alu_src          (in_EX_alu_src),
        .in_EX_alu_op           (in_EX_alu_op),
        .in_MEM_mem_write       (in_MEM_mem_write),
        .in_MEM_mem_read        (in_MEM_mem_read),
        .in_MEM_branch_inst     (in_MEM_branch_inst),
        .in_WB_write_mem_to_reg (in_WB_write_mem_to_reg),
        .in_WB_write_enable     (in_WB_write_enable),
        .in_pc                  (in_pc),
        .in_rs1_data            (in_rs1_data),
        .in_rs2_data            (in_rs2_data),
        .in_imm                 (in_imm),
        .in_rs1                 (in_rs1),
        .in_rs2                 (in_rs2),
        .in_rd                  (in_rd),
        .out_valid              (out_valid),
        .out_EX_alu_src         (out_EX_alu_src),
        .out_EX_alu_op          (out_EX_alu_op),
        .out_MEM_mem_write      (out_MEM_mem_write),
        .out_MEM_mem_read       (out_MEM_mem_read),
        .out_MEM_branch_inst    (out_MEM_branch_inst),
        .out_WB_write_mem_to_reg(out_WB_write_mem_to_reg),
        .out_WB_write_enable    (out_WB_write_enable),
        .out_pc                 (out_pc),
        .out_rs1_data           (out_rs1_data),
        .out_rs2_data           (out_rs2_data),
        .out_imm                (out_imm),
        .out_rs1                (out_rs1),
        .out_rs2                (out_rs2),
        .out_rd                 (out_rd),
`ifdef ID_EX_PERF_CNT_EN
        .out_bubble_cnt         (out_bubble_cnt),
`endif
        .out_id_stall           (out_id_stall)
    );

    logic [152:0] dut_out;
    assign dut_out = {out_valid, out_EX_alu_src, out_EX_alu_op, out_MEM_mem_write,
                      out_MEM_mem_read, out_MEM_branch_inst, out_WB_write_mem_to_reg,
                      out_WB_write_enable, out_pc, out_rs1_data, out_rs2_data, out_imm,
                      out_rs1, out_rs2, out_rd};

    int           n_cmp = 0;
    int           n_bad = 0;
    vec_t         tv[$];
    logic [152:0] exp_q[$];

    function automatic vec_t mk(input logic rst, input logic vld, input logic stl,
                                input logic fls, input logic [8:0] c, input int rs1,
                                input int rs2, input int rd, input logic [31:0] imm,
                                input int kind, input logic st, input logic hz);
        vec_t v;
        v.rst = rst; v.vld = vld; v.stl = stl; v.fls = fls; v.ctrl = c;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd); v.imm = imm;
        v.kind = kind; v.exp_stall = st; v.hz = hz;
        return v;
    endfunction

    task automatic drive(input vec_t v, input int i);
        reset = v.rst; in_valid = v.vld; in_stall = v.stl; in_flush = v.fls;
        {in_EX_alu_src, in_EX_alu_op, in_MEM_mem_write, in_MEM_mem_read, in_MEM_branch_inst,
         in_WB_write_mem_to_reg, in_WB_write_enable} = v.ctrl;
        in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd; in_imm = v.imm;
        in_pc = 32'h1000 + 32'(i * 4);
        in_rs1_data = $urandom;
        in_rs2_data = $urandom;
    endtask

    initial begin
        logic [152:0] last_exp;
        logic [152:0] e;
        logic [31:0]  exp_cnt;

        //          rst vld stl fls ctrl   rs1 rs2 rd imm     kind   st  hz
        tv.push_back(mk(1, 1, 0, 0, C_ADD,  2, 3, 1, 0,  KBub,  0, 0));
        tv.push_back(mk(0, 1, 0, 0, C_ADD,  2, 3, 1, 0,  KCap,  0, 0)); // add x1,x2,x3
        tv.push_back(mk(0, 1, 0, 0, C_LW,   2, 0, 1, 4,  KCap,  0, 0)); // lw x1,4(x2)
        tv.push_back(mk(0, 1, 0, 0, C_ADD,  1, 3, 5, 0,  KBub,  1, 1)); // add x5,x1,x3
        tv.push_back(mk(0, 1, 0, 0, C_ADD,  1, 3, 5, 0,  KCap,  0, 0));
        tv.push_back(mk(0, 1, 0, 0, C_LW,   2, 0, 0, 0,  KCap,  0, 0)); // lw x0,0(x2)
        tv.push_back(mk(0, 1, 0, 0, C_ADD,  0, 3, 5, 0,  KCap,  0, 0)); // add x5,x0,x3
        tv.push_back(mk(0, 1, 0, 0, C_LW,   5, 0, 6, 0,  KCap,  0, 0)); // lw x6,0(x5)
        tv.push_back(mk(0, 1, 0, 0, C_LW,   6, 0, 7, 0,  KBub,  1, 1)); // lw x7,0(x6)
        tv.push_back(mk(0, 1, 0, 0, C_LW,   6, 0, 7, 0,  KCap,  0, 0));
        tv.push_back(mk(0, 1, 0, 0, C_ADD,  3, 7, 8, 0,  KBub,  1, 1)); // rs2 match
        tv.push_back(mk(0, 1, 0, 0, C_ADD,  3, 7, 8, 0,  KCap,  0, 0));
        tv.push_back(mk(0, 0, 0, 0, C_SUB,  8, 8, 9, 0,  KBub,  0, 0)); // empty decode
        tv.push_back(mk(0, 1, 0, 0, C_ADDI, 1, 0, 1, 5,  KCap,  0, 0)); // addi x1,x1,5
        tv.push_back(mk(0, 1, 1, 0, C_LW,   1, 0, 2, 16, KHold, 0, 0));
        tv.push_back(mk(0, 1, 1, 0, C_SW,   3, 4, 0, 8,  KHold, 0, 0));
        tv.push_back(mk(0, 0, 1, 0, C_ADD,  1, 1, 1, 0,  KHold, 0, 0));
        tv.push_back(mk(0, 1, 0, 0, C_LW,   9, 0, 2, 0,  KCap,  0, 0)); // lw x2,0(x9)
        tv.push_back(mk(0, 1, 1, 0, C_ADD,  2, 2, 3, 0,  KHold, 0, 0)); // stall masks hazard
        tv.push_back(mk(0, 1, 0, 0, C_ADD,  2, 2, 3, 0,  KBub,  1, 1));
        tv.push_back(mk(0, 1, 0, 0, C_ADD,  2, 2, 3, 0,  KCap,  0, 0));
        tv.push_back(mk(0, 1, 0, 0, C_SW,   2, 1, 0, 8,  KCap,  0, 0)); // sw x1,8(x2)
        tv.push_back(mk(0, 1, 1, 1, C_ADD,  1, 2, 4, 0,  KBub,  0, 0)); // flush beats stall
        tv.push_back(mk(0, 1, 0, 0, C_LW,   2, 0, 1, 0,  KCap,  0, 0));
        tv.push_back(mk(0, 1, 0, 1, C_ADD,  1, 3, 5, 0,  KBub,  0, 0)); // flush, not counted
        tv.push_back(mk(0, 1, 0, 0, C_LW,   2, 0, 1, 0,  KCap,  0, 0));
        tv.push_back(mk(1, 1, 0, 0, C_ADD,  1, 3, 5, 0,  KBub,  1, 0)); // reset mid-hazard
        tv.push_back(mk(0, 1, 0, 0, C_ADD,  1, 3, 5, 0,  KCap,  0, 0));
        tv.push_back(mk(0, 1, 0, 0, C_BEQ,  5, 1, 0, 12, KCap,  0, 0));
        tv.push_back(mk(0, 0, 0, 0, C_ADD,  0, 0, 0, 0,  KBub,  0, 0));

        drive(tv[0], 0);
        @(posedge clk);
        #1;
        last_exp = '0;
        exp_cnt  = '0;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i], i);
            #2;
            n_cmp++;
            if (out_id_stall !== tv[i].exp_stall) begin
                n_bad++;
                $display("FAIL id_stall[%0d]: got %b want %b", i, out_id_stall,
                         tv[i].exp_stall);
            end
            case (tv[i].kind)
                KCap:    e = {1'b1, tv[i].ctrl, in_pc, in_rs1_data, in_rs2_data, tv[i].imm,
                              tv[i].rs1, tv[i].rs2, tv[i].rd};
                KHold:   e = last_exp;
                default: e = '0;
            endcase
            if (tv[i].rst) begin
                e       = '0;
                exp_cnt = '0;
            end else if (tv[i].hz) begin
                exp_cnt = exp_cnt + 32'd1;
            end
            last_exp = e;
            exp_q.push_back(e);

            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (dut_out !== e) begin
                n_bad++;
                $display("FAIL ex_bundle[%0d]: got %h want %h", i, dut_out, e);
            end
`ifdef ID_EX_PERF_CNT_EN
            n_cmp++;
            if (out_bubble_cnt !== exp_cnt) begin
                n_bad++;
                $display("FAIL bubble_cnt[%0d]: got %0d want %0d", i, out_bubble_cnt,
                         exp_cnt);
            end
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
